// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm sequencer: match detect, ring, auto-stop, snooze, re-ring
//
// Compares the running time against the stored alarm time and sequences the
// buzzer drive through OFF / ARMED / RINGING / SNOOZE.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   sec_tick              one-clk pulse per second
//   turn_on               alarm enable switch (level)
//   snooze_bttn/stop_bttn debounced single-cycle pulses
//   current_mode          2'b10 = set-alarm mode, matching suppressed
//   clock_* / alarm_*     running time and stored alarm time (binary)
//   alarm_going_off       high while RINGING
//   snoozing              high while SNOOZE
//   state                 OFF=00 ARMED=01 RINGING=10 SNOOZE=11
//   snooze_count          snoozes used in the current alarm event

module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic       turn_on,
  input  logic       snooze_bttn,
  input  logic       stop_bttn,
  input  logic [1:0] current_mode,
  input  logic [7:0] clock_hours,
  input  logic [7:0] clock_minutes,
  input  logic [7:0] clock_seconds,
  input  logic [7:0] alarm_hours,
  input  logic [7:0] alarm_minutes,
  input  logic [7:0] alarm_seconds,
  output logic       alarm_going_off,
  output logic       snoozing,
  output logic [1:0] state,
  output logic [1:0] snooze_count
);

  localparam int RW = $clog2(RING_SECS + 1);
  localparam int SW = $clog2(SNOOZE_SECS + 1);

  localparam logic [RW-1:0] RING_LOAD   = RW'(RING_SECS);
  localparam logic [SW-1:0] SNOOZE_LOAD = SW'(SNOOZE_SECS);
  localparam logic [RW-1:0] RING_ONE    = RW'(1);
  localparam logic [SW-1:0] SNOOZE_ONE  = SW'(1);
  localparam logic [1:0]    MAX_CNT     = 2'(MAX_SNOOZES);

  localparam logic [1:0] S_OFF     = 2'b00;
  localparam logic [1:0] S_ARMED   = 2'b01;
  localparam logic [1:0] S_RINGING = 2'b10;
  localparam logic [1:0] S_SNOOZE  = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic [1:0]    count_q, count_d;
  logic          match_q;
  logic          match;
  logic          trigger;

  assign match = (clock_hours   == alarm_hours)   &&
                 (clock_minutes == alarm_minutes) &&
                 (clock_seconds == alarm_seconds) &&
                 (current_mode != 2'b10);

  // Only the first cycle of a match arms the ring, so a stop inside the
  // matching second, or enabling the alarm during it, cannot start a ring.
  assign trigger = match & ~match_q;

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snooze_cnt_d = snooze_cnt_q;
    count_d      = count_q;

    if (!turn_on) begin
      state_d = S_OFF;
      count_d = 2'd0;
    end else begin
      case (state_q)
        S_OFF: begin
          state_d = S_ARMED;
        end
        S_ARMED: begin
          if (trigger) begin
            state_d    = S_RINGING;
            ring_cnt_d = RING_LOAD;
            count_d    = 2'd0;
          end
        end
        S_RINGING: begin
          if (stop_bttn) begin
            state_d = S_ARMED;
            count_d = 2'd0;
          end else if (snooze_bttn) begin
            // Snooze presses beyond the allowance leave the ring going.
            if (count_q < MAX_CNT) begin
              state_d      = S_SNOOZE;
              snooze_cnt_d = SNOOZE_LOAD;
              count_d      = count_q + 2'd1;
            end
          end else if (sec_tick) begin
            if (ring_cnt_q == RING_ONE) begin
              state_d = S_ARMED;
              count_d = 2'd0;
            end else if (ring_cnt_q > RING_ONE) begin
              ring_cnt_d = ring_cnt_q - RING_ONE;
            end
          end
        end
        S_SNOOZE: begin
          if (stop_bttn) begin
            state_d = S_ARMED;
            count_d = 2'd0;
          end else if (sec_tick) begin
            if (snooze_cnt_q == SNOOZE_ONE) begin
              state_d    = S_RINGING;
              ring_cnt_d = RING_LOAD;
            end else if (snooze_cnt_q > SNOOZE_ONE) begin
              snooze_cnt_d = snooze_cnt_q - SNOOZE_ONE;
            end
          end
        end
        default: begin
          state_d = S_OFF;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_OFF;
      ring_cnt_q   <= '0;
      snooze_cnt_q <= '0;
      count_q      <= 2'd0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snooze_cnt_q <= snooze_cnt_d;
      count_q      <= count_d;
      match_q      <= match;
    end
  end

  assign alarm_going_off = (state_q == S_RINGING);
  assign snoozing        = (state_q == S_SNOOZE);
  assign state           = state_q;
  assign snooze_count    = count_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - self-checking bench for alarm_ctrl against a behavioural model

module tb_alarm_ctrl;

  localparam int RING_SECS   = 60;
  localparam int SNOOZE_SECS = 300;
  localparam int MAX_SNOOZES = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       sec_tick;
  logic       turn_on;
  logic       snooze_bttn;
  logic       stop_bttn;
  logic [1:0] current_mode;
  logic [7:0] clock_hours, clock_minutes, clock_seconds;
  logic [7:0] alarm_hours, alarm_minutes, alarm_seconds;
  logic       alarm_going_off;
  logic       snoozing;
  logic [1:0] state;
  logic [1:0] snooze_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alarm_ctrl #(
    .RING_SECS  (RING_SECS),
    .SNOOZE_SECS(SNOOZE_SECS),
    .MAX_SNOOZES(MAX_SNOOZES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sec_tick       (sec_tick),
    .turn_on        (turn_on),
    .snooze_bttn    (snooze_bttn),
    .stop_bttn      (stop_bttn),
    .current_mode   (current_mode),
    .clock_hours    (clock_hours),
    .clock_minutes  (clock_minutes),
    .clock_seconds  (clock_seconds),
    .alarm_hours    (alarm_hours),
    .alarm_minutes  (alarm_minutes),
    .alarm_seconds  (alarm_seconds),
    .alarm_going_off(alarm_going_off),
    .snoozing       (snoozing),
    .state          (state),
    .snooze_count   (snooze_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase-elapsed tick counters counting up, named modes.
  typedef enum int { M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNOOZE = 3 } mode_t;
  mode_t m_mode    = M_OFF;
  int    m_elapsed = 0;
  int    m_snoozes = 0;
  bit    m_seen_match = 1'b0;
  bit    cmp_en = 1'b0;

  wire times_equal = (clock_hours == alarm_hours) && (clock_minutes == alarm_minutes) &&
                     (clock_seconds == alarm_seconds) && (current_mode != 2'b10);

  always @(posedge clk) begin
    if (reset) begin
      m_mode       <= M_OFF;
      m_elapsed    <= 0;
      m_snoozes    <= 0;
      m_seen_match <= 1'b0;
    end else begin
      m_seen_match <= times_equal;
      if (!turn_on) begin
        m_mode    <= M_OFF;
        m_snoozes <= 0;
      end else if (m_mode == M_OFF) begin
        m_mode <= M_ARMED;
      end else if (m_mode == M_ARMED) begin
        if (times_equal && !m_seen_match) begin
          m_mode    <= M_RING;
          m_elapsed <= 0;
          m_snoozes <= 0;
        end
      end else if (m_mode == M_RING) begin
        if (stop_bttn) begin
          m_mode    <= M_ARMED;
          m_snoozes <= 0;
        end else if (snooze_bttn) begin
          if (m_snoozes < MAX_SNOOZES) begin
            m_mode    <= M_SNOOZE;
            m_elapsed <= 0;
            m_snoozes <= m_snoozes + 1;
          end
        end else if (sec_tick) begin
          if (m_elapsed + 1 >= RING_SECS) begin
            m_mode    <= M_ARMED;
            m_snoozes <= 0;
          end else begin
            m_elapsed <= m_elapsed + 1;
          end
        end
      end else begin
        if (stop_bttn) begin
          m_mode    <= M_ARMED;
          m_snoozes <= 0;
        end else if (sec_tick) begin
          if (m_elapsed + 1 >= SNOOZE_SECS) begin
            m_mode    <= M_RING;
            m_elapsed <= 0;
          end else begin
            m_elapsed <= m_elapsed + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_state", {30'd0, state}, m_mode);
      check("model_going_off", {31'd0, alarm_going_off}, {31'd0, m_mode == M_RING});
      check("model_snoozing", {31'd0, snoozing}, {31'd0, m_mode == M_SNOOZE});
      check("model_snooze_count", {30'd0, snooze_count}, m_snoozes);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    clock_hours   = 8'(h);
    clock_minutes = 8'(m);
    clock_seconds = 8'(s);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sec_tick = 1'b1;
      step();
      sec_tick = 1'b0;
      step();
    end
  endtask

  task automatic press_snooze();
    snooze_bttn = 1'b1;
    step();
    snooze_bttn = 1'b0;
  endtask

  task automatic press_stop();
    stop_bttn = 1'b1;
    step();
    stop_bttn = 1'b0;
  endtask

  // Walk the clock into the alarm second and out again.
  task automatic ring_up();
    set_time(7, 29, 59);
    step();
    set_time(7, 30, 0);
    step();
    set_time(7, 30, 1);
  endtask

  initial begin
    reset = 1'b1;
    sec_tick = 1'b0;
    turn_on = 1'b0;
    snooze_bttn = 1'b0;
    stop_bttn = 1'b0;
    current_mode = 2'b00;
    alarm_hours = 8'd7;
    alarm_minutes = 8'd30;
    alarm_seconds = 8'd0;
    set_time(7, 29, 59);
    step();
    cmp_en = 1'b1;
    step();
    check("reset_state", {30'd0, state}, 32'd0);
    check("reset_outputs", {28'd0, alarm_going_off, snoozing, snooze_count}, 32'd0);

    reset = 1'b0;
    turn_on = 1'b1;
    step();
    check("armed_after_enable", {30'd0, state}, 32'd1);

    // 1: ring on match, auto-stop after RING_SECS ticks
    ring_up();
    check("t1_ringing", {31'd0, alarm_going_off}, 32'd1);
    ticks(RING_SECS - 1);
    check("t1_still_ringing_59", {30'd0, state}, 32'd2);
    ticks(1);
    check("t1_auto_stop", {30'd0, state}, 32'd1);
    check("t1_alarm_off", {31'd0, alarm_going_off}, 32'd0);

    // 2: snooze, re-ring after SNOOZE_SECS ticks, full ring reloaded
    ring_up();
    press_snooze();
    check("t2_snooze_state", {30'd0, state}, 32'd3);
    check("t2_snooze_count", {30'd0, snooze_count}, 32'd1);
    check("t2_alarm_off", {31'd0, alarm_going_off}, 32'd0);
    ticks(SNOOZE_SECS - 1);
    check("t2_still_snoozing", {31'd0, snoozing}, 32'd1);
    ticks(1);
    check("t2_rering", {31'd0, alarm_going_off}, 32'd1);
    ticks(RING_SECS - 1);
    check("t2_ring_reloaded", {30'd0, state}, 32'd2);

    // 3: snooze allowance exhausted, then stop
    press_snooze();
    ticks(SNOOZE_SECS);
    press_snooze();
    ticks(SNOOZE_SECS);
    check("t3_count_3", {30'd0, snooze_count}, 32'd3);
    press_snooze();
    check("t3_4th_ignored", {30'd0, state}, 32'd2);
    press_stop();
    check("t3_stop_state", {30'd0, state}, 32'd1);
    check("t3_stop_count", {30'd0, snooze_count}, 32'd0);

    // 4: stop and snooze together; stop inside the match second
    set_time(7, 29, 59);
    step();
    set_time(7, 30, 0);
    step();
    check("t4_ringing", {30'd0, state}, 32'd2);
    stop_bttn = 1'b1;
    snooze_bttn = 1'b1;
    sec_tick = 1'b1;
    step();
    stop_bttn = 1'b0;
    snooze_bttn = 1'b0;
    sec_tick = 1'b0;
    check("t4_stop_wins", {30'd0, state}, 32'd1);
    repeat (4) step();
    check("t4_no_retrigger", {30'd0, state}, 32'd1);

    // 5: set-alarm mode suppresses match; enabling during match second
    set_time(7, 29, 59);
    step();
    current_mode = 2'b10;
    set_time(7, 30, 0);
    step();
    step();
    check("t5_mode_suppress", {30'd0, state}, 32'd1);
    set_time(7, 30, 1);
    step();
    current_mode = 2'b00;
    turn_on = 1'b0;
    set_time(7, 29, 59);
    step();
    check("t5_off", {30'd0, state}, 32'd0);
    set_time(7, 30, 0);
    step();
    turn_on = 1'b1;
    step();
    step();
    step();
    check("t5_enable_in_match", {30'd0, state}, 32'd1);
    set_time(7, 30, 1);
    step();

    // 6: turn_on drop mid-snooze; reset mid-ring
    ring_up();
    press_snooze();
    ticks(5);
    turn_on = 1'b0;
    step();
    check("t6_off_state", {30'd0, state}, 32'd0);
    check("t6_off_count", {30'd0, snooze_count}, 32'd0);
    turn_on = 1'b1;
    step();
    ring_up();
    ticks(3);
    check("t6_ringing", {31'd0, alarm_going_off}, 32'd1);
    reset = 1'b1;
    step();
    check("t6_reset_outputs", {28'd0, alarm_going_off, snoozing, snooze_count}, 32'd0);
    check("t6_reset_state", {30'd0, state}, 32'd0);
    reset = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
